// File: rtl/pixel_cmd_pkg.sv
// pixel_cmd_pkg: character codes, colours, entry width and char-to-RGB decode for pixel_cmd_queue
package pixel_cmd_pkg;
  localparam int ENTRY_W = 28;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_BAR   = 8'h7C;
  localparam logic [7:0] CH_DASH  = 8'h2D;
  localparam logic [7:0] CH_HEAD  = 8'h6F;
  localparam logic [7:0] CH_BODY  = 8'h2A;
  localparam logic [7:0] CH_FOOD  = 8'h23;
  localparam logic [7:0] CH_CLEAR = 8'h0C;
  localparam logic [11:0] RGB_BLACK = 12'h000;
  localparam logic [11:0] RGB_WHITE = 12'hFFF;
  localparam logic [11:0] RGB_SNAKE = 12'h0F7;
  localparam logic [11:0] RGB_FOOD  = 12'h00F;
  typedef enum logic {S_IDLE, S_CLEAR} state_t;
  function automatic logic [11:0] decode(input logic [7:0] c);
    return (c == CH_BAR  || c == CH_DASH) ? RGB_WHITE :
           (c == CH_HEAD || c == CH_BODY) ? RGB_SNAKE :
           (c == CH_FOOD)                 ? RGB_FOOD  : RGB_BLACK;
  endfunction
endpackage

// File: rtl/pixel_cmd_queue_sync_fifo.sv
// sync_fifo: first-word fall-through FIFO with level-derived full/empty and sync active-low reset
module sync_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] level_q, level_d;
  logic do_push, do_pop;
  assign full  = level_q == (AW+1)'(DEPTH);
  assign empty = level_q == '0;
  assign level = level_q;
  assign rdata = mem_q[rd_q];
  // pointer and occupancy update; a push into a full FIFO only succeeds alongside a pop
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_d    = do_push ? wr_q + AW'(1) : wr_q;
    rd_d    = do_pop ? rd_q + AW'(1) : rd_q;
    level_d = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  // storage is not reset; only pointers and level are
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end
  // pointer and level registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end
endmodule

// File: rtl/pixel_cmd_queue.sv
// pixel_cmd_queue: edge-detects CPU pixel commands, decodes colour, queues them to the framebuffer; CLEAR_SCREEN_EN adds a clear sweep on code 0x0C
module pixel_cmd_queue
  import pixel_cmd_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int COLS  = 240,
  parameter int ROWS  = 135
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [31:0]             led_data,
  output logic                    pix_valid,
  input  logic                    pix_ready,
  output logic [10:0]             pix_x,
  output logic [10:0]             pix_y,
  output logic [11:0]             pix_rgb,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic [7:0]              drop_cnt
);
  logic [24:0] prev_q, prev_d;
  logic overflow_q, overflow_d;
  logic [7:0] drop_q, drop_d;
  logic cmd, is_clear, want_push, fifo_push, fifo_pop, drop, full, empty, clearing;
  logic [ENTRY_W-1:0] head;
  logic [10:0] sw_x, sw_y;
  logic unused_bits;
  assign unused_bits = ^led_data[31:25];
  assign cmd = led_data[24] && (led_data[24:0] != prev_q);
`ifdef CLEAR_SCREEN_EN
  state_t state_q, state_d;
  logic [10:0] cx_q, cx_d, cy_q, cy_d;
  assign is_clear = led_data[7:0] == CH_CLEAR;
  assign clearing = state_q == S_CLEAR;
  assign sw_x = cx_q;
  assign sw_y = cy_q;
  // sweep the whole screen raster-order, x fastest; a clear seen mid-sweep is simply not queued
  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    if (state_q == S_IDLE) begin
      if (cmd && is_clear) state_d = S_CLEAR;
    end else if (pix_ready) begin
      cx_d = (cx_q == 11'(COLS-1)) ? '0 : cx_q + 11'd1;
      if (cx_q == 11'(COLS-1)) begin
        cy_d    = (cy_q == 11'(ROWS-1)) ? '0 : cy_q + 11'd1;
        state_d = (cy_q == 11'(ROWS-1)) ? S_IDLE : S_CLEAR;
      end
    end
  end
  // clear FSM state and sweep counters
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
    end
  end
`else
  assign is_clear = 1'b0;
  assign clearing = 1'b0;
  assign sw_x = '0;
  assign sw_y = '0;
`endif
  // queue handshake, drop accounting and output mux; the FIFO is frozen while a sweep owns the port
  always_comb begin
    want_push  = cmd && !is_clear;
    fifo_pop   = !empty && pix_ready && !clearing;
    fifo_push  = want_push && (!full || fifo_pop);
    drop       = want_push && full && !fifo_pop;
    prev_d     = led_data[24:0];
    overflow_d = overflow_q | drop;
    drop_d     = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    pix_valid  = clearing || !empty;
    pix_x      = clearing ? sw_x : {3'b0, head[19:12]};
    pix_y      = clearing ? sw_y : {3'b0, head[27:20]};
    pix_rgb    = clearing ? RGB_BLACK : head[11:0];
  end
  // strobe history and sticky drop status
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      prev_q     <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      prev_q     <= prev_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end
  assign overflow = overflow_q;
  assign drop_cnt = drop_q;
  sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (Clk),
    .rst_n (Rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({led_data[23:16], led_data[15:8], decode(led_data[7:0])}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );
endmodule

// File: tb/tb_pixel_cmd_queue.sv
// tb_pixel_cmd_queue: directed self-checking bench for pixel_cmd_queue (clear sweep section runs when CLEAR_SCREEN_EN is defined)
module tb_pixel_cmd_queue;
  logic Clk = 1'b0;
  logic Rst = 1'b0;
  logic [31:0] led_data = '0;
  logic pix_ready = 1'b0;
  logic pix_valid, overflow;
  logic [10:0] pix_x, pix_y;
  logic [11:0] pix_rgb;
  logic [4:0] level;
  logic [7:0] drop_cnt;
  int n_chk = 0;
  int n_fail = 0;
  int transfers;
  logic [7:0] codes [6] = '{8'h20, 8'h7C, 8'h2D, 8'h2A, 8'h23, 8'h41};
  logic [11:0] rgbs [6] = '{12'h000, 12'hFFF, 12'hFFF, 12'h0F7, 12'h00F, 12'h000};
  pixel_cmd_queue #(.DEPTH(16), .COLS(4), .ROWS(2)) dut (
    .Clk(Clk), .Rst(Rst), .led_data(led_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb), .level(level), .overflow(overflow), .drop_cnt(drop_cnt)
  );
  always #5 Clk = ~Clk;
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    tick();
    tick();
    check("rst_level", 32'(level), 0);
    check("rst_valid", 32'(pix_valid), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_drop", 32'(drop_cnt), 0);
    Rst = 1'b1;
    tick();
    pix_ready = 1'b1;
    led_data = 32'h0103_056F;
    check("no_bypass", 32'(pix_valid), 0);
    transfers = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (i == 0) begin
        check("lat1_valid", 32'(pix_valid), 1);
        check("lat1_x", 32'(pix_x), 5);
        check("lat1_y", 32'(pix_y), 3);
        check("lat1_rgb", 32'(pix_rgb), 32'h0F7);
      end
      if (pix_valid && pix_ready) transfers++;
    end
    check("hold_once", transfers, 1);
    check("hold_level", 32'(level), 0);
    pix_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      led_data = {7'b0, 1'b1, 8'(i), 8'(i + 10), 8'h23};
      tick();
    end
    check("fill_level", 32'(level), 16);
    check("fill_ovf", 32'(overflow), 1);
    check("fill_drop", 32'(drop_cnt), 4);
    check("head0_x", 32'(pix_x), 10);
    check("head0_y", 32'(pix_y), 0);
    led_data = 32'h0132_3C7C;
    pix_ready = 1'b1;
    tick();
    check("fullpop_level", 32'(level), 16);
    check("fullpop_drop", 32'(drop_cnt), 4);
    for (int i = 1; i < 16; i++) begin
      check("drain_x", 32'(pix_x), 32'(i + 10));
      check("drain_y", 32'(pix_y), 32'(i));
      check("drain_rgb", 32'(pix_rgb), 32'h00F);
      tick();
    end
    check("late_x", 32'(pix_x), 60);
    check("late_y", 32'(pix_y), 50);
    check("late_rgb", 32'(pix_rgb), 32'hFFF);
    tick();
    check("drained", 32'(level), 0);
    check("drained_valid", 32'(pix_valid), 0);
    pix_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      led_data = {7'b0, 1'b1, 8'(i), 8'd0, codes[i]};
      tick();
    end
    check("dec_level", 32'(level), 6);
    pix_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("dec_rgb", 32'(pix_rgb), 32'(rgbs[i]));
      check("dec_y", 32'(pix_y), 32'(i));
      tick();
    end
    pix_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      led_data = {7'b0, 1'b1, 8'(i + 100), 8'd7, 8'h20};
      tick();
    end
    check("pre_rst_level", 32'(level), 5);
    check("pre_rst_ovf", 32'(overflow), 1);
    Rst = 1'b0;
    tick();
    Rst = 1'b1;
    check("mid_rst_level", 32'(level), 0);
    check("mid_rst_valid", 32'(pix_valid), 0);
    check("mid_rst_ovf", 32'(overflow), 0);
    check("mid_rst_drop", 32'(drop_cnt), 0);
    led_data = '0;
    tick();
    check("post_rst_level", 32'(level), 0);
    for (int i = 0; i < 276; i++) begin
      led_data = {7'b0, 1'b1, 8'(i >> 8) + 8'h80, 8'(i), 8'h20};
      tick();
    end
    check("sat_drop", 32'(drop_cnt), 255);
    check("sat_level", 32'(level), 16);
`ifdef CLEAR_SCREEN_EN
    Rst = 1'b0;
    tick();
    Rst = 1'b1;
    led_data = '0;
    tick();
    pix_ready = 1'b1;
    led_data = 32'h0100_000C;
    tick();
    led_data = 32'h0101_0123;
    for (int k = 0; k < 8; k++) begin
      check("clr_valid", 32'(pix_valid), 1);
      check("clr_x", 32'(pix_x), 32'(k % 4));
      check("clr_y", 32'(pix_y), 32'(k / 4));
      check("clr_rgb", 32'(pix_rgb), 0);
      tick();
    end
    check("after_clr_x", 32'(pix_x), 1);
    check("after_clr_y", 32'(pix_y), 1);
    check("after_clr_rgb", 32'(pix_rgb), 32'h00F);
    tick();
    check("after_clr_idle", 32'(pix_valid), 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
